adc_capture_ctrl: RTL and testbench

Sequencing controller for the oscilloscope front end. Paces conversions on the ADC SPI master at a programmable sample rate and detects a level/slope trigger. Captures a pre-/post-trigger frame into the sample memory, then flags the frame to the display side. It sits between the ADC SPI master (conversion start/done handshake) and the capture RAM write port.

---
 rtl/adc_capture_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// Oscilloscope capture sequencer: paces ADC conversions, detects level/slope
// triggers and writes a pre/post-trigger frame into a circular capture RAM.
module adc_capture_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              trig_auto,
  input  logic [ADDR_W-1:0] pretrig,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              frame_ready,
  output logic              busy,
  output logic              overrun
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, POST, DONE} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d, rate_q, rate_d;
  logic [DATA_W-1:0]   lvl_q, lvl_d, prev_q, prev_d, mem_wdata_q, mem_wdata_d;
  logic                slope_q, slope_d, auto_q, auto_d, have_prev_q, have_prev_d;
  logic [ADDR_W-1:0]   pre_q, pre_d, wptr_q, wptr_d, mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc, post_need;
  logic                outst_q, outst_d, discard_q, discard_d, overrun_q, overrun_d;
  logic                conv_start_q, conv_start_d, mem_we_q, mem_we_d;
  logic                frame_ready_q, frame_ready_d, busy_q, busy_d;
  logic                running, tick, wr, trig_hit;

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    rate_d        = rate_q;
    lvl_d         = lvl_q;
    slope_d       = slope_q;
    auto_d        = auto_q;
    pre_d         = pre_q;
    prev_d        = prev_q;
    have_prev_d   = have_prev_q;
    wptr_d        = wptr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    trig_addr_d   = trig_addr_q;
    cnt_d         = cnt_q;
    outst_d       = outst_q;
    discard_d     = discard_q;
    overrun_d     = overrun_q;
    conv_start_d  = 1'b0;
    mem_we_d      = 1'b0;

    running   = (state_q == ARM) || (state_q == WAIT_TRIG) || (state_q == POST);
    tick      = running && (div_q == rate_q);
    wr        = conv_done && running && !discard_q && !arm;
    cnt_inc   = cnt_q + 1'b1;
    post_need = LAST - {1'b0, pre_q};
    trig_hit  = have_prev_q && (slope_q ? (prev_q >= lvl_q && conv_data < lvl_q)
                                        : (prev_q <  lvl_q && conv_data >= lvl_q));
    frame_ready_d = (state_q == DONE);
    busy_d        = running;

    if (running) div_d = tick ? '0 : div_q + 1'b1;

    if (conv_done) begin
      outst_d   = 1'b0;
      discard_d = 1'b0;
    end

    // A conversion finishing in the same cycle frees the slot for this tick.
    if (tick) begin
      if (outst_q && !conv_done) overrun_d = 1'b1;
      else begin
        conv_start_d = 1'b1;
        outst_d      = 1'b1;
      end
    end

    if (wr) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = wptr_q;
      mem_wdata_d = conv_data;
      wptr_d      = wptr_q + 1'b1;
      prev_d      = conv_data;
      have_prev_d = 1'b1;
      cnt_d       = cnt_inc;
      case (state_q)
        ARM: if (cnt_inc == {1'b0, pre_q}) begin
          state_d = WAIT_TRIG;
          cnt_d   = '0;
        end
        WAIT_TRIG: if (trig_hit || (auto_q && cnt_q == LAST)) begin
          trig_addr_d = wptr_q;
          cnt_d       = '0;
          state_d     = (post_need == '0) ? DONE : POST;
        end
        POST: if (cnt_inc == post_need) state_d = DONE;
        default: ;
      endcase
    end

    // Restart wins over everything; an in-flight conversion is marked for discard.
    if (arm) begin
      rate_d        = rate_div;
      lvl_d         = trig_level;
      slope_d       = trig_slope;
      auto_d        = trig_auto;
      pre_d         = pretrig;
      div_d         = '0;
      cnt_d         = '0;
      wptr_d        = '0;
      mem_addr_d    = '0;
      have_prev_d   = 1'b0;
      overrun_d     = 1'b0;
      frame_ready_d = 1'b0;
      busy_d        = 1'b1;
      conv_start_d  = 1'b0;
      outst_d       = outst_q && !conv_done;
      discard_d     = outst_q && !conv_done;
      state_d       = (pretrig == '0) ? WAIT_TRIG : ARM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      div_q         <= '0;
      rate_q        <= '0;
      lvl_q         <= '0;
      slope_q       <= 1'b0;
      auto_q        <= 1'b0;
      pre_q         <= '0;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      wptr_q        <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      trig_addr_q   <= '0;
      cnt_q         <= '0;
      outst_q       <= 1'b0;
      discard_q     <= 1'b0;
      overrun_q     <= 1'b0;
      conv_start_q  <= 1'b0;
      mem_we_q      <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      rate_q        <= rate_d;
      lvl_q         <= lvl_d;
      slope_q       <= slope_d;
      auto_q        <= auto_d;
      pre_q         <= pre_d;
      prev_q        <= prev_d;
      have_prev_q   <= have_prev_d;
      wptr_q        <= wptr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      trig_addr_q   <= trig_addr_d;
      cnt_q         <= cnt_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
      overrun_q     <= overrun_d;
      conv_start_q  <= conv_start_d;
      mem_we_q      <= mem_we_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign conv_start  = conv_start_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign trig_addr   = trig_addr_q;
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a fixed-latency ADC model and
// monitors that log conv_start pulses and capture RAM writes by cycle.
module tb_adc_capture_ctrl;
  localparam int DATA_W = 12, ADDR_W = 5, DIV_W = 16;

  logic clk = 0, reset = 0, arm = 0, trig_slope = 0, trig_auto = 0;
  logic [DIV_W-1:0]  rate_div = 0;
  logic [DATA_W-1:0] trig_level = 0, conv_data = 0;
  logic [ADDR_W-1:0] pretrig = 0;
  logic conv_start, conv_done = 0, mem_we, frame_ready, busy, overrun;
  logic [ADDR_W-1:0] mem_addr, trig_addr;
  logic [DATA_W-1:0] mem_wdata;

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .rate_div(rate_div),
    .trig_level(trig_level), .trig_slope(trig_slope), .trig_auto(trig_auto),
    .pretrig(pretrig), .conv_start(conv_start), .conv_done(conv_done),
    .conv_data(conv_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .trig_addr(trig_addr), .frame_ready(frame_ready),
    .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, arm_cyc = 0;
  int adc_lat = 2, adc_cnt = 0, mode = 0, sample_idx = 0;
  bit adc_pend = 0;
  int start_cyc[$], wr_cyc[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] sample_val(int i);
    case (mode)
      0: return DATA_W'(100 * (i % 20));
      1: return DATA_W'(500);
      2: return (i < 8) ? DATA_W'(2000) : DATA_W'(10);
      default: return DATA_W'(i);
    endcase
  endfunction

  // ADC: conv_done asserted adc_lat cycles after conv_start is seen
  always begin
    @(posedge clk); #1;
    conv_done = 0;
    if (reset) adc_pend = 0;
    else begin
      if (adc_pend) begin
        if (adc_cnt == 1) begin
          conv_done = 1;
          conv_data = sample_val(sample_idx);
          sample_idx++;
          adc_pend = 0;
        end else adc_cnt--;
      end
      if (conv_start) begin
        adc_pend = 1;
        adc_cnt  = adc_lat;
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (conv_start) start_cyc.push_back(cyc);
    if (mem_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic clear_logs();
    start_cyc.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; arm = 0;
    repeat (2) @(negedge clk);
    reset = 0; sample_idx = 0;
    clear_logs();
  endtask

  task automatic do_arm(int rate, int lvl, bit slope, bit auto_t, int pre);
    @(negedge clk);
    rate_div = DIV_W'(rate); trig_level = DATA_W'(lvl); trig_slope = slope;
    trig_auto = auto_t; pretrig = ADDR_W'(pre); arm = 1;
    clear_logs();
    @(negedge clk); arm = 0; arm_cyc = cyc;
  endtask

  task automatic wait_frame(int budget, output bit ok, output int rdy_cyc);
    ok = 0; rdy_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_ready) begin ok = 1; rdy_cyc = cyc; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1; #12;
    checks++; if (conv_start !== 0 || mem_we !== 0) begin errors++; $display("FAIL reset_strobes start=%b we=%b want 0", conv_start, mem_we); end
    checks++; if (mem_addr !== 0 || trig_addr !== 0) begin errors++; $display("FAIL reset_addr mem_addr=%0d trig_addr=%0d want 0", mem_addr, trig_addr); end
    checks++; if (frame_ready !== 0 || busy !== 0 || overrun !== 0) begin errors++; $display("FAIL reset_flags ready=%b busy=%b ovr=%b want 0", frame_ready, busy, overrun); end
    @(negedge clk); reset = 0; sample_idx = 0; clear_logs();
  endtask

  task automatic test_pacing();
    do_reset(); mode = 3; adc_lat = 2;
    do_arm(3, 4095, 0, 0, 0);
    checks++; if (busy !== 1) begin errors++; $display("FAIL pace_busy got %b want 1", busy); end
    repeat (40) @(negedge clk);
    checks++; if (start_cyc.size() < 5) begin errors++; $display("FAIL pace_count got %0d want >=5", start_cyc.size()); end
    else begin
      checks++; if (start_cyc[0] - arm_cyc != 4) begin errors++; $display("FAIL pace_first got %0d want 4", start_cyc[0] - arm_cyc); end
      for (int i = 1; i < 5; i++) begin
        checks++; if (start_cyc[i] - start_cyc[i-1] != 4) begin errors++; $display("FAIL pace_period[%0d] got %0d want 4", i, start_cyc[i] - start_cyc[i-1]); end
      end
    end
    checks++; if (overrun !== 0) begin errors++; $display("FAIL pace_overrun got %b want 0", overrun); end
    if (wr_cyc.size() < 3) begin checks++; errors++; $display("FAIL pace_writes got %0d want >=3", wr_cyc.size()); end
    else begin
      checks++; if (wr_cyc[0] - arm_cyc != 7) begin errors++; $display("FAIL pace_wr_lat got %0d want 7", wr_cyc[0] - arm_cyc); end
      checks++; if (wr_addr[2] !== 2 || wr_data[2] !== 2) begin errors++; $display("FAIL pace_wr2 addr=%0d data=%0d want 2/2", wr_addr[2], wr_data[2]); end
    end
  endtask

  task automatic test_overrun();
    do_reset(); mode = 3; adc_lat = 5;
    do_arm(1, 4095, 0, 0, 0);
    repeat (7) @(negedge clk);
    checks++; if (start_cyc.size() != 1) begin errors++; $display("FAIL ovr_starts got %0d want 1", start_cyc.size()); end
    checks++; if (overrun !== 1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
    do_arm(1, 4095, 0, 0, 0);
    checks++; if (overrun !== 0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
    adc_lat = 2;
  endtask

  task automatic test_pretrig_rising();
    bit ok; int rc, ns, nw;
    do_reset(); mode = 0; adc_lat = 2;
    do_arm(3, 1000, 0, 0, 16);
    wait_frame(400, ok, rc);
    checks++; if (!ok) begin errors++; $display("FAIL rise_timeout frame_ready=%b want 1", frame_ready); end
    else begin
      checks++; if (trig_addr !== 30) begin errors++; $display("FAIL rise_trig_addr got %0d want 30", trig_addr); end
      checks++; if (wr_addr.size() != 46) begin errors++; $display("FAIL rise_writes got %0d want 46", wr_addr.size()); end
      checks++; if (wr_data.size() > 30 && wr_data[30] !== 1000) begin errors++; $display("FAIL rise_trig_data got %0d want 1000", wr_data[30]); end
      checks++; if (wr_addr[$] !== 13) begin errors++; $display("FAIL rise_last_addr got %0d want 13", wr_addr[$]); end
      checks++; if (rc != wr_cyc[$] + 1) begin errors++; $display("FAIL rise_ready_time got %0d want %0d", rc, wr_cyc[$] + 1); end
      checks++; if (busy !== 0) begin errors++; $display("FAIL rise_busy got %b want 0", busy); end
      ns = start_cyc.size(); nw = wr_addr.size();
      repeat (20) @(negedge clk);
      checks++; if (start_cyc.size() != ns || wr_addr.size() != nw) begin errors++; $display("FAIL rise_quiet starts=%0d writes=%0d want %0d/%0d", start_cyc.size(), wr_addr.size(), ns, nw); end
      checks++; if (frame_ready !== 1) begin errors++; $display("FAIL rise_ready_hold got %b want 1", frame_ready); end
    end
  endtask

  task automatic test_auto_trigger();
    bit ok; int rc;
    do_reset(); mode = 1; adc_lat = 2;
    do_arm(3, 1000, 0, 1, 0);
    wait_frame(400, ok, rc);
    checks++; if (!ok) begin errors++; $display("FAIL auto_timeout frame_ready=%b want 1", frame_ready); end
    else begin
      checks++; if (trig_addr !== 31) begin errors++; $display("FAIL auto_trig_addr got %0d want 31", trig_addr); end
      checks++; if (wr_addr.size() != 63) begin errors++; $display("FAIL auto_writes got %0d want 63", wr_addr.size()); end
      checks++; if (wr_addr[$] !== 30) begin errors++; $display("FAIL auto_last_addr got %0d want 30", wr_addr[$]); end
    end
  endtask

  task automatic test_falling();
    bit ok; int rc;
    do_reset(); mode = 2; adc_lat = 2;
    do_arm(3, 1000, 1, 0, 4);
    wait_frame(400, ok, rc);
    checks++; if (!ok) begin errors++; $display("FAIL fall_timeout frame_ready=%b want 1", frame_ready); end
    else begin
      checks++; if (trig_addr !== 8) begin errors++; $display("FAIL fall_trig_addr got %0d want 8", trig_addr); end
      checks++; if (wr_addr.size() != 36) begin errors++; $display("FAIL fall_writes got %0d want 36", wr_addr.size()); end
      checks++; if (wr_addr[$] !== 3) begin errors++; $display("FAIL fall_last_addr got %0d want 3", wr_addr[$]); end
    end
  endtask

  task automatic test_rearm_outstanding();
    bit seen = 0;
    do_reset(); mode = 2; adc_lat = 2;
    do_arm(3, 1000, 1, 0, 4);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (wr_addr.size() >= 12 && conv_start) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rearm_timeout writes=%0d want >=12", wr_addr.size()); end
    else begin
      arm = 1; clear_logs();
      @(negedge clk); arm = 0; arm_cyc = cyc;
      checks++; if (frame_ready !== 0 || mem_addr !== 0 || busy !== 1) begin errors++; $display("FAIL rearm_state ready=%b addr=%0d busy=%b want 0/0/1", frame_ready, mem_addr, busy); end
      repeat (6) @(negedge clk);
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL rearm_discard writes=%0d want 0", wr_addr.size()); end
      repeat (6) @(negedge clk);
      checks++; if (wr_addr.size() == 0 || wr_addr[0] !== 0) begin errors++; $display("FAIL rearm_addr0 writes=%0d want first at 0", wr_addr.size()); end
      checks++; if (start_cyc.size() == 0 || start_cyc[0] - arm_cyc != 4) begin errors++; $display("FAIL rearm_first_start n=%0d want at +4", start_cyc.size()); end
    end
  endtask

  task automatic test_reset_mid();
    int ns, nw;
    do_reset(); mode = 3; adc_lat = 2;
    do_arm(3, 4095, 0, 0, 0);
    repeat (10) @(negedge clk);
    reset = 1; #2;
    checks++; if (busy !== 0 || mem_we !== 0 || conv_start !== 0) begin errors++; $display("FAIL midreset_out busy=%b we=%b start=%b want 0", busy, mem_we, conv_start); end
    @(negedge clk); reset = 0;
    ns = start_cyc.size(); nw = wr_addr.size();
    repeat (20) @(negedge clk);
    checks++; if (start_cyc.size() != ns || wr_addr.size() != nw) begin errors++; $display("FAIL midreset_quiet starts=%0d writes=%0d want %0d/%0d", start_cyc.size(), wr_addr.size(), ns, nw); end
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_overrun();
    test_pretrig_rising();
    test_auto_trigger();
    test_falling();
    test_rearm_outstanding();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
